// File: rtl/adder_seq_pkg.sv
// adder_seq_pkg: shared state encoding and default geometry for the word-serial adder
package adder_seq_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ADD = 2'd1, DONE = 2'd2} state_t;
  localparam int DEF_NUM_BITS = 4;
  localparam int DEF_NUM_WORDS = 4;
endpackage

// File: rtl/adder_nbit.sv
// adder_nbit: combinational NUM_BITS-wide ripple adder with carry in/out
module adder_nbit #(
  parameter int NUM_BITS = 4
) (
  input  logic [NUM_BITS-1:0] a,
  input  logic [NUM_BITS-1:0] b,
  input  logic                carry_in,
  output logic [NUM_BITS-1:0] sum,
  output logic                overflow
);
  assign {overflow, sum} = {1'b0, a} + {1'b0, b} + (NUM_BITS+1)'(carry_in);
endmodule

// File: rtl/adder_word_sequencer.sv
// adder_word_sequencer: wide unsigned add done one word per cycle through a single adder_nbit
module adder_word_sequencer
  import adder_seq_pkg::*;
#(
  parameter int NUM_BITS = DEF_NUM_BITS,
  parameter int NUM_WORDS = DEF_NUM_WORDS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [NUM_BITS*NUM_WORDS-1:0] op_a,
  input  logic [NUM_BITS*NUM_WORDS-1:0] op_b,
  input  logic                          carry_in,
  output logic                          busy,
  output logic                          done,
  output logic [NUM_BITS*NUM_WORDS-1:0] result,
  output logic                          overflow
);
  localparam int W = NUM_BITS * NUM_WORDS;
  localparam int CW = (NUM_WORDS > 2) ? $clog2(NUM_WORDS) : 1;
  state_t state, next;
  logic [W-1:0] a_sh, b_sh, acc;
  logic c_reg;
  logic [CW-1:0] word_cnt;
  logic [NUM_BITS-1:0] sum;
  logic ov;
  logic last;
  adder_nbit #(.NUM_BITS(NUM_BITS)) u_add (
    .a(a_sh[NUM_BITS-1:0]),
    .b(b_sh[NUM_BITS-1:0]),
    .carry_in(c_reg),
    .sum(sum),
    .overflow(ov)
  );
  assign last = word_cnt == CW'(NUM_WORDS - 1);
  assign busy = state == ADD || state == DONE;
  assign done = state == DONE;
  always_comb begin
    next = IDLE;
    next = state == IDLE ? (start ? ADD : IDLE) : state == ADD ? (last ? DONE : ADD) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_sh <= '0;
      b_sh <= '0;
      acc <= '0;
      c_reg <= 1'b0;
      word_cnt <= '0;
      result <= '0;
      overflow <= 1'b0;
    end else begin
      state <= next;
      if (state == IDLE && start) begin
        a_sh <= op_a;
        b_sh <= op_b;
        c_reg <= carry_in;
        word_cnt <= '0;
        acc <= '0;
      end else if (state == ADD) begin
        // sum words enter at the top so the LS word ends up at the bottom after NUM_WORDS shifts
        a_sh <= a_sh >> NUM_BITS;
        b_sh <= b_sh >> NUM_BITS;
        acc <= {sum, acc[W-1:NUM_BITS]};
        c_reg <= ov;
        word_cnt <= word_cnt + 1'b1;
        if (last) begin
          result <= {sum, acc[W-1:NUM_BITS]};
          overflow <= ov;
        end
      end
    end
  end
endmodule

// File: tb/tb_adder_word_sequencer.sv
// tb_adder_word_sequencer: directed and randomized checks of the word-serial adder
module tb_adder_word_sequencer;
  logic clk = 0, rst = 1, start = 0, carry_in = 0;
  logic [15:0] op_a = 0, op_b = 0, result;
  logic busy, done, overflow;
  int checks = 0, errors = 0;

  adder_word_sequencer #(.NUM_BITS(4), .NUM_WORDS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .carry_in(carry_in), .busy(busy), .done(done), .result(result), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b, input logic c);
    return 17'(a) + 17'(b) + 17'(c);
  endfunction

  // launches one op and waits for done; lat counts negedges after the accept edge
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                       input logic [15:0] prev_res, input logic prev_ov,
                       output int lat, output logic held);
    @(negedge clk);
    op_a = a; op_b = b; carry_in = c; start = 1;
    @(negedge clk);
    start = 0; op_a = $urandom; op_b = $urandom; carry_in = $urandom;
    lat = 1; held = 1;
    while (!done && lat < 20) begin
      if (result !== prev_res || overflow !== prev_ov) held = 0;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    checks++;
    if ({busy, done, result, overflow} !== 19'h0) begin
      errors++; $display("FAIL reset_state got busy=%b done=%b result=%h ov=%b want 0 0 0000 0", busy, done, result, overflow);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 0 || done !== 0) begin
      errors++; $display("FAIL idle_hold got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_op(input string name, input logic [15:0] a, input logic [15:0] b, input logic c);
    int lat; logic held; logic [16:0] exp;
    logic [15:0] pr; logic po;
    pr = result; po = overflow;
    exp = model(a, b, c);
    do_op(a, b, c, pr, po, lat, held);
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL %s_latency got %0d want 5", name, lat); end
    checks++;
    if (result !== exp[15:0] || overflow !== exp[16]) begin
      errors++; $display("FAIL %s_result got %h/%b want %h/%b", name, result, overflow, exp[15:0], exp[16]);
    end
    checks++;
    if (!held) begin errors++; $display("FAIL %s_hold got changed want %h/%b", name, pr, po); end
    @(negedge clk);
    checks++;
    if (done !== 0 || busy !== 0) begin
      errors++; $display("FAIL %s_back_idle got busy=%b done=%b want 0 0", name, busy, done);
    end
  endtask

  task automatic test_basic();
    test_op("basic", 16'h1234, 16'h4321, 0);
    checks++;
    if (result !== 16'h5555 || overflow !== 0) begin
      errors++; $display("FAIL basic_const got %h/%b want 5555/0", result, overflow);
    end
  endtask

  task automatic test_carry_ripple();
    test_op("ripple", 16'hFFFF, 16'h0000, 1);
    checks++;
    if (result !== 16'h0000 || overflow !== 1) begin
      errors++; $display("FAIL ripple_const got %h/%b want 0000/1", result, overflow);
    end
  endtask

  task automatic test_ignore_start();
    int n = 0;
    @(negedge clk);
    op_a = 16'h8000; op_b = 16'h8000; carry_in = 0; start = 1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      if (done) n++;
      start = i < 4;
      op_a = 16'h0001; op_b = 16'h0001;
      @(negedge clk);
    end
    start = 0;
    checks++;
    if (n !== 1) begin errors++; $display("FAIL ignore_done_count got %0d want 1", n); end
    checks++;
    if (result !== 16'h0000 || overflow !== 1) begin
      errors++; $display("FAIL ignore_result got %h/%b want 0000/1", result, overflow);
    end
  endtask

  task automatic test_reset_abort();
    int n = 0;
    @(negedge clk);
    op_a = 16'h00FF; op_b = 16'h0001; carry_in = 0; start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    checks++;
    if (busy !== 0 || result !== 16'h0 || overflow !== 0) begin
      errors++; $display("FAIL abort_state got busy=%b result=%h ov=%b want 0 0000 0", busy, result, overflow);
    end
    for (int i = 0; i < 8; i++) begin
      if (done) n++;
      @(negedge clk);
    end
    checks++;
    if (n !== 0) begin errors++; $display("FAIL abort_no_done got %0d want 0", n); end
  endtask

  task automatic test_back_to_back();
    int n = 0, last_t = -1, bad_gap = 0, bad_res = 0;
    @(negedge clk);
    op_a = 16'h0F0F; op_b = 16'h0101; carry_in = 0; start = 1;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (done) begin
        n++;
        if (last_t >= 0 && t - last_t != 6) bad_gap++;
        if (result !== 16'h1010 || overflow !== 0) bad_res++;
        last_t = t;
      end
    end
    start = 0;
    repeat (8) @(negedge clk);
    checks++;
    if (n < 6) begin errors++; $display("FAIL b2b_count got %0d want >=6", n); end
    checks++;
    if (bad_gap != 0) begin errors++; $display("FAIL b2b_period got %0d bad gaps want 0", bad_gap); end
    checks++;
    if (bad_res != 0) begin errors++; $display("FAIL b2b_result got %0d bad results want 0", bad_res); end
  endtask

  task automatic test_random();
    int lat; logic held; logic [16:0] exp;
    logic [15:0] a, b, pr; logic c, po;
    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom); b = 16'($urandom); c = 1'($urandom);
      if (i % 8 == 0) a = 16'hFFFF - b;
      exp = model(a, b, c);
      pr = result; po = overflow;
      do_op(a, b, c, pr, po, lat, held);
      checks++;
      if (lat !== 5 || result !== exp[15:0] || overflow !== exp[16] || !held) begin
        errors++;
        $display("FAIL rand_%0d got lat=%0d res=%h ov=%b held=%b want lat=5 res=%h ov=%b held=1",
                 i, lat, result, overflow, held, exp[15:0], exp[16]);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry_ripple();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/adder_word_sequencer.md
Name: adder_word_sequencer

Overview:
Multi-precision addition controller that sequences one existing combinational adder_nbit instance, NUM_BITS wide, over NUM_WORDS cycles. It adds two NUM_BITS*NUM_WORDS-bit unsigned operands one word per cycle, least-significant word first. The carry is registered between cycles. It gives ALU-side logic wide additions without instantiating a wide adder, using a start/busy/done handshake.

Parameters:
NUM_BITS, 4, width of the adder_nbit datapath (one word)
NUM_WORDS, 4, number of words per operand; total width W = NUM_BITS*NUM_WORDS; must be >= 2

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request pulse/level; sampled only in IDLE
op_a  input  W  operand A, captured when start is accepted
op_b  input  W  operand B, captured when start is accepted
carry_in  input  1  initial carry, captured when start is accepted
busy  output  1  high in ADD and DONE states
done  output  1  one-cycle completion strobe (high in DONE state)
result  output  W  registered sum; stable between completions
overflow  output  1  registered final carry-out of most-significant word

Behaviour:
- Single clock, synchronous active-high reset.
  - rst=1 at an edge forces state IDLE, clears all internal registers, and sets busy=0, done=0, result=0, overflow=0.
  - rst has priority over everything, including mid-operation. An aborted operation produces no done and leaves result/overflow at 0.
- FSM states: IDLE, ADD, DONE.
  - IDLE -> ADD when start=1 at an edge. On that edge:
    - a_sh<=op_a, b_sh<=op_b, c_reg<=carry_in
    - word_cnt<=0, acc<=0
  - Operands changing after acceptance have no effect.
  - ADD: adder_nbit inputs are a=a_sh[NUM_BITS-1:0], b=b_sh[NUM_BITS-1:0], carry_in=c_reg. Each ADD edge:
    - a_sh and b_sh shift right by NUM_BITS (zero fill)
    - acc shifts right by NUM_BITS, with adder sum inserted at acc[W-1:W-NUM_BITS]
    - c_reg<=adder overflow
    - word_cnt<=word_cnt+1
  - ADD -> DONE on the edge where word_cnt==NUM_WORDS-1 (the last word). On that same edge:
    - result<=final shifted acc value, including the last sum word
    - overflow<=adder overflow
  - DONE -> IDLE unconditionally on the next edge. start is ignored in DONE.
- word_cnt width is $clog2(NUM_WORDS), minimum 1; it never wraps during an operation.
- Timing: start sampled at edge 0; word i is added at edge i+1; done=1 for exactly the cycle after edge NUM_WORDS. The earliest next acceptance is edge NUM_WORDS+2, so throughput is one op per NUM_WORDS+2 cycles.
- start in ADD/DONE is ignored, not queued.
- start held high continuously causes back-to-back operations using the op_a/op_b values present at each IDLE edge.
- result/overflow change only on the ADD->DONE edge or on reset. They hold through IDLE and through the next operation's ADD cycles.
- Arithmetic is unsigned modulo 2^W; overflow is the carry out of bit W-1. The carry ripples across words via c_reg; no combinational path spans words.
- done and busy are decoded from registered state only (no input-to-output combinational path).

Decomposition:
- Shared package adder_seq_pkg holds:
  - the state enum typedef (IDLE, ADD, DONE), 2-bit encoding
  - default NUM_BITS/NUM_WORDS localparams
- Sub-module: the existing adder_nbit, instantiated once as the datapath with width NUM_BITS. The sequencer contains only the FSM, shift registers, carry register, counter and output registers.

Test Plan:
Defaults NUM_BITS=4, NUM_WORDS=4, W=16.
1. rst=1 for 2 edges, then 0 -> busy=0, done=0, result=16'h0000, overflow=0; IDLE holds with start=0.
2. op_a=16'h1234, op_b=16'h4321, carry_in=0, start one cycle -> busy=1 from next cycle; done=1 only in the cycle after edge 4; result=16'h5555, overflow=0.
3. op_a=16'hFFFF, op_b=16'h0000, carry_in=1 -> carry ripples through all 4 words; result=16'h0000, overflow=1.
4. op_a=16'h8000, op_b=16'h8000, carry_in=0 -> result=16'h0000, overflow=1. During ADD, drive start=1 with op_a=16'h0001, op_b=16'h0001: ignored, exactly one done, result unchanged.
5. Start op_a=16'h00FF, op_b=16'h0001, then assert rst on the second ADD edge -> next cycle busy=0, done never pulses, result=16'h0000, overflow=0.
6. start held high with op_a=16'h0F0F, op_b=16'h0101 -> done pulses every 6 cycles, result=16'h1010 each time. Randomized checks against op_a+op_b+carry_in: 1000 vectors, result and overflow compared at each done.
